// File: rtl/lu_pkg.sv
// Shared types, width helper and FSM encoding for the LU row store.
// Element layout is {imag, real}; real occupies the low half of each element.
package lu_pkg;

    localparam int unsigned LU_SIZE  = 32;
    localparam int unsigned LU_WIDTH = 64;

    typedef struct packed {
        logic [LU_WIDTH-1:0] im;
        logic [LU_WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [LU_SIZE-1:0] row_t;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } lu_state_t;

    function automatic int unsigned lu_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lu_perm_table.sv
// Logical-to-physical row permutation with a sequential clear walk.
// Parity tracking exists only when LU_ROW_STORE_PARITY_EN is defined.
module lu_perm_table
    import lu_pkg::*;
#(
    parameter  int unsigned SIZE = 32,
    localparam int unsigned AW   = lu_aw(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_req,
    input  logic          swap_valid,
    input  logic [AW-1:0] swap_a,
    input  logic [AW-1:0] swap_b,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_phys,
    output logic [AW-1:0] wr_phys,
    output logic          idle,
    output logic          accept,
    output logic          busy,
    output logic          parity
);
    lu_state_t     state, state_nx;
    logic [AW-1:0] perm [SIZE];
    logic [AW-1:0] cnt;
    logic          swap_go;

    // A clear request blocks same-cycle writes and swaps.
    assign idle    = (state == ST_READY);
    assign accept  = rst_n && idle && !clear_req;
    assign busy    = rst_n && (state == ST_CLEAR);
    assign swap_go = accept && swap_valid;
    assign rd_phys = perm[rd_addr];
    assign wr_phys = perm[wr_addr];

    always_comb begin
        state_nx = state;
        case (state)
            ST_READY: if (clear_req) state_nx = ST_CLEAR;
            ST_CLEAR: if (cnt == AW'(SIZE - 1)) state_nx = ST_READY;
            default:  state_nx = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_READY;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int unsigned k = 0; k < SIZE; k++) perm[k] <= AW'(k);
        end else if (state == ST_CLEAR) begin
            perm[cnt] <= cnt;
            cnt       <= cnt + 1'b1;
        end else if (clear_req) begin
            cnt <= '0;
        end else if (swap_go) begin
            perm[swap_a] <= perm[swap_b];
            perm[swap_b] <= perm[swap_a];
        end
    end

`ifdef LU_ROW_STORE_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (!rst_n)                              par <= 1'b0;
        else if (idle && clear_req)              par <= 1'b0;
        else if (swap_go && (swap_a != swap_b))  par <= ~par;
    end

    assign parity = rst_n && par;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: rtl/lu_row_store.sv
// Row store for LU factorisation: permuted row access, swaps, and a pipelined read port.
// Optional parity output is enabled by defining LU_ROW_STORE_PARITY_EN.
module lu_row_store
    import lu_pkg::*;
#(
    parameter  int unsigned SIZE   = 32,
    parameter  int unsigned WIDTH  = 64,
    parameter  int unsigned RD_LAT = 1,
    localparam int unsigned AW     = lu_aw(SIZE),
    localparam int unsigned RW     = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rd_valid_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_valid_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [RW-1:0] rd_row_o,
    input  logic          wr_valid_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [RW-1:0] wr_row_i,
    output logic          wr_ready_o,
    input  logic          swap_valid_i,
    input  logic [AW-1:0] swap_a_i,
    input  logic [AW-1:0] swap_b_i,
    output logic          swap_ready_o,
    input  logic          perm_clear_i,
    output logic          busy_o,
    output logic          perm_parity_o
);
    logic [RW-1:0] mem [SIZE];
    logic [AW-1:0] rd_phys, wr_phys, src_phys;
    logic          idle, accept, rd_fire, wr_fire;
    logic          pv [RD_LAT];
    logic [AW-1:0] pa [RD_LAT];
    logic [RW-1:0] row_q;

    lu_perm_table #(.SIZE(SIZE)) u_perm (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .clear_req  (perm_clear_i),
        .swap_valid (swap_valid_i),
        .swap_a     (swap_a_i),
        .swap_b     (swap_b_i),
        .rd_addr    (rd_addr_i),
        .wr_addr    (wr_addr_i),
        .rd_phys    (rd_phys),
        .wr_phys    (wr_phys),
        .idle       (idle),
        .accept     (accept),
        .busy       (busy_o),
        .parity     (perm_parity_o)
    );

    assign rd_fire      = rd_valid_i && idle;
    assign wr_fire      = wr_valid_i && accept;
    assign wr_ready_o   = accept;
    assign swap_ready_o = accept;
    assign rd_valid_o   = rst_ni && pv[RD_LAT-1];
    assign rd_addr_o    = pa[RD_LAT-1];
    assign rd_row_o     = row_q;

    // Row data is sampled one cycle before delivery, so writes landing in flight are seen.
    if (RD_LAT == 1) begin : g_lat1
        assign src_phys = rd_phys;
    end else begin : g_latn
        logic [AW-1:0] pp [RD_LAT-1];
        always_ff @(posedge clk_i) begin
            pp[0] <= rd_phys;
            for (int unsigned i = 1; i < RD_LAT - 1; i++) pp[i] <= pp[i-1];
        end
        assign src_phys = pp[RD_LAT-2];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= rd_fire;
            for (int unsigned i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        pa[0] <= rd_addr_i;
        for (int unsigned i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
        if (wr_fire) mem[wr_phys] <= wr_row_i;
        row_q <= (wr_fire && (wr_phys == src_phys)) ? wr_row_i : mem[src_phys];
    end

endmodule

// File: doc/lu_row_store.md
LU_ROW_STORE -- requirements
Module: lu_row_store

Interface
- REQ-001 SHALL have parameter SIZE, default 32: matrix rows, and complex elements per row; power of two, minimum 2.
- REQ-002 SHALL have parameter WIDTH, default 64: bits per real or imaginary part (IEEE double when 64).
- REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal range 1..4.
- REQ-004 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset); one clock; reset is synchronous and active-low.
- REQ-005 SHALL have the read port:
  - rd_valid_i (in, 1), rd_addr_i (in, AW=$clog2(SIZE)): logical row to read.
  - rd_valid_o (out, 1), rd_addr_o (out, AW), rd_row_o (out, SIZE*2*WIDTH): returned row; element j is {imag,real} at bits [j*2W +: 2W].
- REQ-006 SHALL have the write port: wr_valid_i (in, 1), wr_addr_i (in, AW), wr_row_i (in, SIZE*2*WIDTH), wr_ready_o (out, 1).
- REQ-007 SHALL have the swap port: swap_valid_i (in, 1), swap_a_i (in, AW), swap_b_i (in, AW), swap_ready_o (out, 1).
- REQ-008 SHALL have the control port: perm_clear_i (in, 1) requests identity permutation; busy_o (out, 1) is high while clearing; perm_parity_o (out, 1) is the permutation parity.

Function
- REQ-009 SHALL map a logical row to a physical row as phys = perm[logical] for reads and writes.
- REQ-010 SHALL present, for an accepted read in cycle t, rd_valid_o, rd_addr_o and rd_row_o in cycle t+RD_LAT; back-to-back reads every cycle are supported.
- REQ-011 SHALL accept a write when wr_valid_i && wr_ready_o, updating the physical row at the next edge.
- REQ-012 SHALL return the new data when a read and a write to the same logical row occur in the same cycle (write-first forwarding).
  - Forwarding also covers a write landing while a read to the same row is in flight.
- REQ-013 SHALL, on an accepted swap, exchange perm[a] and perm[b] in one cycle; row data is not moved.
- REQ-014 SHALL treat a swap with a==b as a no-op that is still accepted.
- REQ-015 SHALL translate a read or write in the same cycle as a swap through the pre-swap mapping.
- REQ-016 SHALL implement FSM states:
  - READY: rd, wr and swap are accepted.
  - CLEAR: a counter walks 0..SIZE-1 writing perm[k]=k; it lasts SIZE cycles, then returns to READY.
- REQ-017 SHALL enter CLEAR from READY on perm_clear_i; perm_clear_i is ignored while in CLEAR.
- REQ-018 SHALL, in CLEAR, hold wr_ready_o=0, swap_ready_o=0 and busy_o=1, and drop rd_valid_i.
  - Reads already in flight still complete.
- REQ-019 SHALL give perm_clear_i priority over a same-cycle swap or write; both are not accepted.

Reset
- REQ-020 SHALL, on reset, set perm to identity, the FSM to READY, and flush the read pipeline.
- REQ-021 SHALL hold these output values in reset: rd_valid_o=0, busy_o=0, perm_parity_o=0, wr_ready_o=0, swap_ready_o=0.
- REQ-022 SHALL raise wr_ready_o and swap_ready_o in the first cycle after reset.
- REQ-023 SHALL NOT reset row storage contents.
- REQ-024 SHALL abort a CLEAR and drop in-flight reads when reset is asserted mid-operation.

Configuration
- REQ-025 SHALL, with LU_ROW_STORE_PARITY_EN defined, toggle perm_parity_o on every accepted swap with a!=b and clear it on CLEAR entry.
- REQ-026 SHALL, without LU_ROW_STORE_PARITY_EN, tie perm_parity_o to 0 and contain no parity register.

Structure
- REQ-027 SHALL place the following in shared package lu_pkg:
  - typedef cplx_t {imag, real} of WIDTH each.
  - row type = SIZE cplx_t.
  - the AW helper.
  - FSM state enum.
- REQ-028 SHALL keep the permutation table, its clear counter and the parity bit in sub-module lu_perm_table; data storage and the read pipeline stay in lu_row_store.

Verification
- REQ-029 SHALL pass load/readback:
  - Stimulus: SIZE=4, RD_LAT=2; write rows 0..3 with element0.real = 1.0..4.0.
  - Response: a read of row 2 gives 3.0, rd_valid_o exactly 2 cycles later.
- REQ-030 SHALL pass swap:
  - Stimulus: swap(0,3), then read 0 and read 3.
  - Response: 4.0 and 1.0; with the macro defined perm_parity_o=1; a second swap(1,1) leaves parity 1.
- REQ-031 SHALL pass same-cycle write and read:
  - Stimulus: write row 1 with 9.0 and read row 1 in the same cycle.
  - Response: 9.0.
  - Also: swap(1,2) with a read of 1 in the same cycle returns the pre-swap row.
- REQ-032 SHALL pass clear:
  - Stimulus: after swap(0,3), pulse perm_clear_i.
  - Response: busy_o=1 for exactly 4 cycles with wr_ready_o=0; then a read of 0 returns 1.0 and perm_parity_o=0.
- REQ-033 SHALL pass reset mid-clear:
  - Stimulus: assert rst_ni=0 in the 2nd CLEAR cycle.
  - Response: the next cycle shows busy_o=0 and rd_valid_o=0, and the permutation is identity.
- REQ-034 SHALL pass streaming: 100 random reads, writes and swaps at SIZE=32, RD_LAT=3 match a reference model every cycle.
